// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-side and
// data-side cache ports. Data requests win by default, but once STARVE_MAX
// consecutive data grants have been made while an instruction fetch waited,
// the fetch is forced through. Each access is latched at grant, runs until
// ramready, then spends one DONE cycle pulsing the requester's wait low.

module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,

  // Instruction-side request port
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,

  // Data-side request port
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,

  // RAM port
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready
);

  // Counter must hold 0..STARVE_MAX inclusive; keep at least one bit.
  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StIAcc,
    StDAcc,
    StIDone,
    StDDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] store_q;
  logic              op_wr_q;
  logic [WORD_W-1:0] iload_q;
  logic [WORD_W-1:0] dload_q;

  logic d_req;
  logic i_forced;
  logic grant_d;
  logic grant_i;

  assign d_req    = dREN | dWEN;
  // The waiting fetch has seen enough data grants go past it.
  assign i_forced = iREN && (starve_q == CntMax);
  assign grant_d  = (state_q == StIdle) && d_req && !i_forced;
  assign grant_i  = (state_q == StIdle) && iREN && !grant_d;

  // State register
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: non-preemptive, decisions only made from IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StDAcc;
        end else if (grant_i) begin
          state_d = StIAcc;
        end
      end
      StIAcc: begin
        if (ramready) begin
          state_d = StIDone;
        end
      end
      StDAcc: begin
        if (ramready) begin
          state_d = StDDone;
        end
      end
      // DONE gives the requester one edge to drop its request before IDLE.
      StIDone: state_d = StIdle;
      StDDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latches and starvation counter, updated only on a grant
  always_ff @(posedge CLK) begin
    if (nRST) begin
      starve_q <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      op_wr_q  <= 1'b0;
    end else if (grant_d) begin
      addr_q  <= daddr;
      store_q <= dstore;
      // A simultaneous read and write request is serviced as a write.
      op_wr_q <= dWEN;
      if (!iREN) begin
        starve_q <= '0;
      end else if (starve_q != CntMax) begin
        starve_q <= starve_q + 1'b1;
      end
    end else if (grant_i) begin
      addr_q   <= iaddr;
      starve_q <= '0;
    end
  end

  // Read-data capture on RAM completion; write completions leave dload alone
  always_ff @(posedge CLK) begin
    if (nRST) begin
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      if ((state_q == StIAcc) && ramready) begin
        iload_q <= ramload;
      end
      if ((state_q == StDAcc) && ramready && !op_wr_q) begin
        dload_q <= ramload;
      end
    end
  end

  // Output decode from state; RAM enables are only ever high in an ACC state
  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    iwait  = 1'b1;
    dwait  = 1'b1;
    unique case (state_q)
      StIAcc:  ramREN = 1'b1;
      StDAcc: begin
        ramREN = !op_wr_q;
        ramWEN = op_wr_q;
      end
      StIDone: iwait = 1'b0;
      StDDone: dwait = 1'b0;
      default: ;
    endcase
  end

  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign iload    = iload_q;
  assign dload    = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one linear stimulus sequence, outputs
// sampled 1 time unit after each rising edge, inputs changed at that point.

module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W    (32),
    .WORD_W    (32),
    .STARVE_MAX(4)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle-state outputs common to many steps
  task automatic chk_quiet(input string tag);
    chk({tag, "_ramREN"}, 32'(ramREN), 32'd0);
    chk({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
    chk({tag, "_iwait"},  32'(iwait),  32'd1);
    chk({tag, "_dwait"},  32'(dwait),  32'd1);
  endtask

  initial begin
    nRST     = 1'b1;
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramready = 1'b0;

    // Reset state
    step();
    step();
    chk_quiet("rst");
    chk("rst_iload",    iload,    32'h0);
    chk("rst_dload",    dload,    32'h0);
    chk("rst_ramaddr",  ramaddr,  32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    nRST = 1'b0;
    step();
    chk_quiet("rst_rel");

    // Single I read with two RAM wait cycles; iaddr changes mid-access
    iREN  = 1'b1;
    iaddr = 32'h100;
    step();
    chk("i1_ren_c1",  32'(ramREN), 32'd1);
    chk("i1_addr_c1", ramaddr,     32'h100);
    chk("i1_iwait_c1", 32'(iwait), 32'd1);
    iaddr = 32'h200;
    step();
    chk("i1_ren_c2",  32'(ramREN), 32'd1);
    chk("i1_addr_c2", ramaddr,     32'h100);
    step();
    chk("i1_ren_c3",  32'(ramREN), 32'd1);
    chk("i1_addr_c3", ramaddr,     32'h100);
    chk("i1_wen_c3",  32'(ramWEN), 32'd0);
    ramready = 1'b1;
    ramload  = 32'hDEADBEEF;
    step();
    chk("i1_done_iwait", 32'(iwait),  32'd0);
    chk("i1_done_iload", iload,       32'hDEADBEEF);
    chk("i1_done_dwait", 32'(dwait),  32'd1);
    chk("i1_done_ren",   32'(ramREN), 32'd0);
    ramready = 1'b0;
    iREN     = 1'b0;
    step();
    chk_quiet("i1_idle");

    // Simultaneous I and D: D first, then I
    iREN  = 1'b1;
    iaddr = 32'h300;
    dREN  = 1'b1;
    daddr = 32'h80;
    step();
    chk("sim_d_ren",   32'(ramREN), 32'd1);
    chk("sim_d_wen",   32'(ramWEN), 32'd0);
    chk("sim_d_addr",  ramaddr,     32'h80);
    chk("sim_d_iwait", 32'(iwait),  32'd1);
    ramready = 1'b1;
    ramload  = 32'hCAFE0001;
    step();
    chk("sim_d_dwait", 32'(dwait), 32'd0);
    chk("sim_d_dload", dload,      32'hCAFE0001);
    chk("sim_d_iwait2", 32'(iwait), 32'd1);
    ramready = 1'b0;
    dREN     = 1'b0;
    step();
    chk_quiet("sim_idle");
    step();
    chk("sim_i_ren",  32'(ramREN), 32'd1);
    chk("sim_i_addr", ramaddr,     32'h300);
    ramready = 1'b1;
    ramload  = 32'h11112222;
    step();
    chk("sim_i_iwait", 32'(iwait), 32'd0);
    chk("sim_i_iload", iload,      32'h11112222);
    chk("sim_i_dwait", 32'(dwait), 32'd1);
    ramready = 1'b0;
    iREN     = 1'b0;
    step();
    chk_quiet("sim_idle2");

    // Write with dREN and dWEN both set; dload must keep its old value
    dREN   = 1'b1;
    dWEN   = 1'b1;
    daddr  = 32'h40;
    dstore = 32'h12345678;
    step();
    chk("wr_wen",   32'(ramWEN), 32'd1);
    chk("wr_ren",   32'(ramREN), 32'd0);
    chk("wr_addr",  ramaddr,     32'h40);
    chk("wr_store", ramstore,    32'h12345678);
    ramready = 1'b1;
    ramload  = 32'hFFFFFFFF;
    step();
    chk("wr_dwait", 32'(dwait), 32'd0);
    chk("wr_dload", dload,      32'hCAFE0001);
    ramready = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    step();
    chk_quiet("wr_idle");

    // Starvation: four D grants while I waits, then I is forced
    iREN  = 1'b1;
    iaddr = 32'h500;
    dREN  = 1'b1;
    for (int g = 0; g < 4; g++) begin
      daddr = 32'h600 + 32'(g * 4);
      step();
      chk("stv_d_ren",   32'(ramREN), 32'd1);
      chk("stv_d_addr",  ramaddr,     32'h600 + 32'(g * 4));
      ramready = 1'b1;
      ramload  = 32'h0;
      step();
      chk("stv_d_dwait", 32'(dwait), 32'd0);
      chk("stv_d_iwait", 32'(iwait), 32'd1);
      ramready = 1'b0;
      step();
      chk_quiet("stv_idle");
    end
    daddr = 32'h700;
    step();
    chk("stv_i_ren",  32'(ramREN), 32'd1);
    chk("stv_i_wen",  32'(ramWEN), 32'd0);
    chk("stv_i_addr", ramaddr,     32'h500);
    ramready = 1'b1;
    ramload  = 32'hABCD0000;
    step();
    chk("stv_i_iwait", 32'(iwait), 32'd0);
    chk("stv_i_iload", iload,      32'hABCD0000);
    chk("stv_i_dwait", 32'(dwait), 32'd1);
    ramready = 1'b0;
    step();
    chk_quiet("stv_idle2");
    // Counter cleared: D wins again although I is still pending
    step();
    chk("stv_clr_ren",  32'(ramREN), 32'd1);
    chk("stv_clr_addr", ramaddr,     32'h700);

    // Reset in the middle of that D access, before ramready
    step();
    chk("mid_ren", 32'(ramREN), 32'd1);
    nRST = 1'b1;
    step();
    chk_quiet("mid_rst");
    chk("mid_rst_addr",  ramaddr, 32'h0);
    chk("mid_rst_iload", iload,   32'h0);
    nRST     = 1'b0;
    iREN     = 1'b0;
    dREN     = 1'b0;
    ramready = 1'b1;
    ramload  = 32'h55555555;
    step();
    chk_quiet("late_rdy1");
    chk("late_rdy_dload", dload, 32'h0);
    step();
    chk_quiet("late_rdy2");
    ramready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-side and data-side cache request ports.
- Sits between the caches block and RAM, replacing the direct cache-to-RAM wiring.
- Grants one requester at a time; data has priority, with starvation protection for instruction fetch.
- Latches the request at grant and signals completion with a one-cycle wait-low pulse per requester.

Parameters:
- ADDR_W, 32, width of address buses.
- WORD_W, 32, width of data buses.
- STARVE_MAX, 4, consecutive D grants tolerated while iREN is pending before I is forced.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  synchronous reset, active-high; the name follows codebase convention, the polarity is fixed.
- iREN  in  1  instruction read request, held until serviced.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  low for exactly one cycle when the I access completes, otherwise high.
- iload  out  WORD_W  instruction data; valid while iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  WORD_W  write data.
- dwait  out  1  low for exactly one cycle when the D access completes, otherwise high.
- dload  out  WORD_W  read data; valid while dwait is low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data; valid when ramready is high.
- ramready  in  1  RAM access-complete strobe; meaningful only while ramREN or ramWEN is high.

Behaviour:
- States are IDLE, I_ACC, D_ACC, I_DONE, D_DONE. All outputs are registered or decoded from state and latched registers.
- Reset (nRST=1 at an edge):
  - state goes to IDLE;
  - iwait=dwait=1, iload=dload=0;
  - ramREN=ramWEN=0, ramaddr=ramstore=0;
  - starve counter=0.
  - Reset mid-access abandons the access; RAM enables drop in the cycle after that edge.
- IDLE, with d_req = dREN|dWEN:
  - If d_req and not (iREN and starve==STARVE_MAX): go to D_ACC. Latch daddr and dstore. Latch the op: write if dWEN, else read. dWEN&dREN is treated as a write.
  - Else if iREN: go to I_ACC and latch iaddr.
  - Else stay in IDLE.
- Starve counter update on each transition out of IDLE:
  - D grant with iREN high: counter increments, saturating at STARVE_MAX.
  - I grant: counter clears.
  - D grant with iREN low: counter clears.
- I_ACC:
  - ramREN=1, ramaddr=latched iaddr.
  - On ramready: capture ramload into iload and go to I_DONE.
- D_ACC:
  - ramREN or ramWEN per the latched op; ramaddr and ramstore come from the latches.
  - On ramready: go to D_DONE. For reads, capture ramload into dload; for writes, dload is unchanged.
- I_DONE / D_DONE:
  - RAM enables are 0.
  - The matching wait output is 0 for this single cycle.
  - Next state is always IDLE.
  - The DONE cycle gives the requester one edge to drop its request, so the arbiter never re-grants the same request.
- Latency: request sampled at edge N → ACC from N+1 → ramready sampled at edge N+1+k (k≥0 wait cycles) → DONE for one cycle → IDLE. The minimum request-to-wait-low time is 2 cycles.
- Grant is non-preemptive. A request arriving during ACC or DONE is held off (wait=1) until the next IDLE decision.
- ramready outside I_ACC or D_ACC is ignored.
- Input changes during ACC do not affect the in-flight access, because address and data are latched.
- Only one of iwait/dwait is ever low in a given cycle. ramREN and ramWEN are never high together.

Test Plan:
- Single I read: iREN=1, iaddr=0x100, RAM ready after 2 wait cycles with ramload=0xDEADBEEF → ramREN high for 3 cycles with ramaddr=0x100; iwait=0 for exactly 1 cycle with iload=0xDEADBEEF; dwait stays 1.
- Simultaneous requests: iREN=1 and dREN=1 in the same cycle → D served first with ramaddr=daddr. After D_DONE and IDLE, I is served. Each wait goes low exactly once.
- Write with dREN&dWEN=1: daddr=0x40, dstore=0x12345678 → ramWEN=1, ramREN=0, ramstore=0x12345678; dwait low one cycle; dload unchanged.
- Starvation: iREN held, dREN re-asserted every IDLE, STARVE_MAX=4 → after 4 D grants the 5th grant goes to I even with dREN=1; the counter then clears.
- Reset mid-access: nRST=1 during D_ACC before ramready → next cycle ramREN=ramWEN=0, dwait=1, state IDLE; a late ramready is ignored.
- Input change during access: iaddr changed to 0x200 while in I_ACC → ramaddr stays 0x100 until I_DONE.
